// File: rtl/top.sv
// ============================================================================
// Module   : top
// Brief    : Array of CE/SR flip-flop groups fed from switches, with group
//            observation and XOR/OR/AND reductions on the LEDs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top #(
  parameter int NUM_FF = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  localparam int c_NUM_BITS = 4 * NUM_FF;
  localparam int c_NUM_SW   = 14;

  logic                  w_ce;
  logic                  w_sr;
  logic [c_NUM_BITS-1:0] w_d;
  logic [c_NUM_BITS-1:0] w_q;
  logic                  w_unused_rx;

  assign w_ce        = sw[14];
  assign w_sr        = sw[15];
  assign w_unused_rx = rx;

  // Data inputs wrap around the 14 data switches once the groups run past them.
  generate
    for (genvar gi = 0; gi < c_NUM_BITS; gi++) begin : g_dmap
      assign w_d[gi] = sw[gi % c_NUM_SW];
    end
  endgenerate

  generate
    for (genvar gg = 0; gg < NUM_FF; gg++) begin : g_group
      logic r_vcc_gnd = 1'b0;
      logic r_s_gnd   = 1'b0;
      logic r_s_s     = 1'b0;
      logic r_vcc_s   = 1'b0;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_vcc_gnd <= 1'b0;
        end else begin
          r_vcc_gnd <= w_d[4*gg+0];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s_gnd <= 1'b0;
        end else if (w_ce) begin
          r_s_gnd <= w_d[4*gg+1];
        end
      end

      // Synchronous clear wins over clock enable.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_s_s <= 1'b0;
        end else if (w_sr) begin
          r_s_s <= 1'b0;
        end else if (w_ce) begin
          r_s_s <= w_d[4*gg+2];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_vcc_s <= 1'b0;
        end else if (w_sr) begin
          r_vcc_s <= 1'b0;
        end else begin
          r_vcc_s <= w_d[4*gg+3];
        end
      end

      assign w_q[4*gg+0] = r_vcc_gnd;
      assign w_q[4*gg+1] = r_s_gnd;
      assign w_q[4*gg+2] = r_s_s;
      assign w_q[4*gg+3] = r_vcc_s;
    end
  endgenerate

  assign tx = 1'b1;

  always_comb begin
    led        = '0;
    led[3:0]   = w_q[3:0];
    led[4]     = w_q[4];
    led[8:5]   = w_q[c_NUM_BITS-1 -: 4];
    led[9]     = ^w_q;
    led[10]    = |w_q;
    led[11]    = &w_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_top.sv
// ============================================================================
// Module   : tb_top
// Brief    : Vector-table bench for top with NUM_FF=4 (16 flip-flops).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        tx;
  logic [15:0] sw;
  logic [15:0] led;

  int checks;
  int failures;

  top #(.NUM_FF(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .tx    (tx),
    .sw    (sw),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic [15:0] sw;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[13];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: led actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled one falling edge later.
  task automatic apply(input logic r, input logic [15:0] s);
    rst_n = r;
    sw    = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    rx       = 1'b0;
    sw       = 16'h0000;

    // sw layout: [15]=SR, [14]=CE, [13:0]=data
    vecs[0]  = '{"reset",          1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{"idle_zero",      1'b1, 16'h0000, 16'h0000};
    vecs[2]  = '{"ce0_ones",       1'b1, 16'h000F, 16'h0709};
    vecs[3]  = '{"ce1_ones",       1'b1, 16'h400F, 16'h058F};
    vecs[4]  = '{"ce0_zeros_hold", 1'b1, 16'h0000, 16'h0686};
    vecs[5]  = '{"ce1_zeros",      1'b1, 16'h4000, 16'h0000};
    vecs[6]  = '{"sr_over_ce",     1'b1, 16'hC00F, 16'h0403};
    vecs[7]  = '{"sr_release_ce0", 1'b1, 16'h000F, 16'h050B};
    vecs[8]  = '{"sr_release_ce1", 1'b1, 16'h400F, 16'h058F};
    vecs[9]  = '{"all_ones",       1'b1, 16'h7FFF, 16'h0DFF};
    vecs[10] = '{"reset_override", 1'b0, 16'hFFFF, 16'h0000};
    vecs[11] = '{"sr_ce0_ones",    1'b1, 16'hBFFF, 16'h0431};
    vecs[12] = '{"wrap_sw0",       1'b1, 16'h4001, 16'h0481};

    #1;
    check16("powerup", led, 16'h0000);
    check1("powerup_tx", tx, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].rst_n, vecs[i].sw);
      check16(vecs[i].name, led, vecs[i].exp_led);
      check1({vecs[i].name, "_tx"}, tx, 1'b1);
    end

    // State after wrap_sw0: q0 and q14 (group 3 s_s) set. With CE=0, only
    // the CE-gated s_s in group 3 keeps its value across several edges.
    sw = 16'h0000;
    #1;
    check16("no_change_before_edge", led, 16'h0481);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      check16("hold_ce0", led, 16'h0680);
    end

    // Reset asserted mid-stream clears everything; tx idles throughout.
    rst_n = 1'b0;
    sw    = 16'h7FFF;
    @(posedge clk);
    #1;
    check16("reset_mid", led, 16'h0000);
    check1("reset_mid_tx", tx, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check16("reset_release", led, 16'h0DFF);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter NUM_FF, default 4, number of flip-flop groups; the design SHALL support NUM_FF values of 2 or more.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset: synchronous, active-low.
REQ-004 rx  input  1  serial input; unused, no functional effect.
REQ-005 tx  output  1  serial output; SHALL be held constant 1 (idle).
REQ-006 sw  input  16  sw[13:0] data switches; sw[14] = CE control; sw[15] = SR control.
REQ-007 led  output  16  flip-flop observation and reduction outputs (mapping in Function).

Function
REQ-008 Group i (0..NUM_FF-1) SHALL contain four 1-bit FFs; each group SHALL have data inputs D[4i+k] = sw[(4i+k) mod 14] for k=0..3.
REQ-009 FF k=0 ("vcc_gnd") SHALL be a plain D register: Q <= D on every rising edge.
REQ-010 FF k=1 ("s_gnd") SHALL load D only when sw[14]=1 and hold otherwise; it has no SR input.
REQ-011 FF k=2 ("s_s") SHALL use CE=sw[14] and synchronous SR=sw[15]:
- if SR=1, Q <= 0 regardless of CE;
- else if CE=1, Q <= D;
- else Q holds.
REQ-012 FF k=3 ("vcc_s") SHALL use CE tied to 1 and synchronous SR=sw[15]:
- if SR=1, Q <= 0;
- else Q <= D.
REQ-013 SR SHALL take priority over CE in every FF that has an SR input.
REQ-014 The SR and CE controls SHALL be applied to the FFs directly, with no pipeline stage; D-to-Q latency SHALL be exactly one clock edge.
REQ-015 led[3:0] SHALL be Q of group 0, ordered {vcc_s, s_s, s_gnd, vcc_gnd}: led[0]=vcc_gnd, led[1]=s_gnd, led[2]=s_s, led[3]=vcc_s.
REQ-016 led[4] SHALL be Q of group 1 vcc_gnd.
REQ-017 led[8:5] SHALL be Q of group NUM_FF-1: led[5]=vcc_gnd, led[6]=s_gnd, led[7]=s_s, led[8]=vcc_s.
REQ-018 led[9] SHALL be the combinational XOR of all 4*NUM_FF Q bits.
REQ-019 led[10] SHALL be the combinational OR of all 4*NUM_FF Q bits.
REQ-020 led[11] SHALL be the combinational AND of all 4*NUM_FF Q bits.
REQ-021 led[9], led[10] and led[11] SHALL have no register stage beyond the FFs themselves.
REQ-022 led[15:12] SHALL be constant 0.
REQ-023 The sw inputs are treated as synchronous to clk; no synchronizer stages SHALL be added, since they would change the required latency.

Reset
REQ-024 When rst_n=0 at a rising edge, all 4*NUM_FF FFs SHALL become 0, overriding SR, CE and D.
REQ-025 While all FFs are 0 after reset, led[11:0] SHALL read 0; tx SHALL remain 1 during and after reset.
REQ-026 All FFs SHALL also power up / initialize to 0, so that with rst_n held high and sw=0 all led outputs are 0.
REQ-027 Deasserting rst_n SHALL resume normal operation on the next rising edge.

Verification
REQ-028 sw=0, rst_n=1 -> after the first edge: led[11:0]=0 and led[9] equals the XOR of the data inputs (0).
REQ-029 CE=0, sw[3:0]=1111, one edge -> led[0]=1, led[1]=0, led[2]=0, led[3]=1, led[10]=1, led[11]=0.
- Then set CE=1, one edge -> led[3:0]=1111.
REQ-030 CE=0, sw[3:0]=0000, one edge -> led[3:0]=0110 (led[1]=led[2]=1 held, led[0]=led[3]=0).
- Then set CE=1, one edge -> led[3:0]=0000 and led[10]=0.
REQ-031 CE=1, sw[3:0]=1111, SR=1, one edge -> led[0]=1, led[1]=1, led[2]=0, led[3]=0.
- Then set CE=0, SR=0, one edge -> led[3]=1 and led[2] stays 0.
- Then set CE=1, one edge -> led[2]=1.
REQ-032 CE=1, SR=0, sw[13:0]=all ones, one edge -> led[11:0]=all ones except led[9], which SHALL equal the XOR of the 16 D bits (0).
REQ-033 Any state, rst_n=0 for one edge -> led[11:0]=0 and tx=1.
